xsm_capture_sequencer: RTL and testbench

XSM_CAPTURE_SEQUENCER -- requirements
Module: xsm_capture_sequencer

---
 rtl/xsm_capture_pkg.sv | 7 +
 rtl/xsm_ch_priority_find.sv | 35 +++
 rtl/xsm_capture_sequencer.sv | 137 +++++++++++++
 tb/tb_xsm_capture_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xsm_capture_pkg.sv
// rtl/xsm_capture_pkg.sv - shared constants and state encoding for the capture sequencer
package xsm_capture_pkg;
   localparam int NUM_CH = 12;
   localparam int CH_W   = 4;

   typedef enum logic [1:0] {IDLE, SCAN, GAP, DONE} state_e;
endpackage

// File: rtl/xsm_ch_priority_find.sv
// rtl/xsm_ch_priority_find.sv - lowest enabled channel at or above a pointer
module xsm_ch_priority_find #(
   parameter int NUM_CH = xsm_capture_pkg::NUM_CH,
   parameter int CH_W   = xsm_capture_pkg::CH_W
)(
   input  logic [NUM_CH-1:0] i_mask,
   input  logic [CH_W-1:0]   i_ptr,
   output logic              o_found,
   output logic [CH_W-1:0]   o_index,
   output logic              o_is_last
);
   logic            w_found;
   logic            w_above;
   logic [CH_W-1:0] w_idx;

   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      // Descending walk so the lowest qualifying channel is the one left standing.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (i_mask[i] && (i >= int'(i_ptr))) begin
            w_found = 1'b1;
            w_idx   = CH_W'(i);
         end
      end
      w_above = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (i_mask[i] && (i > int'(w_idx))) w_above = 1'b1;
      end
   end

   assign o_found   = w_found;
   assign o_index   = w_idx;
   assign o_is_last = w_found && !w_above;
endmodule

// File: rtl/xsm_capture_sequencer.sv
// rtl/xsm_capture_sequencer.sv - multi-channel ADC capture trigger sequencer
module xsm_capture_sequencer
   import xsm_capture_pkg::CH_W, xsm_capture_pkg::state_e, xsm_capture_pkg::IDLE,
          xsm_capture_pkg::SCAN, xsm_capture_pkg::GAP, xsm_capture_pkg::DONE;
#(
   parameter int NUM_CH = xsm_capture_pkg::NUM_CH,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [NUM_CH-1:0] i_ch_mask,
   input  logic [CNT_W-1:0]  i_gap_cycles,
   input  logic [CNT_W-1:0]  i_scan_count,
   input  logic              i_ds_ready,
   output logic              o_trig_out,
   output logic [CH_W-1:0]   o_trig_ch,
   output logic              o_first_in_scan,
   output logic              o_last_in_scan,
   output logic              o_busy,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_scans_done,
   output logic              o_mask_err
);
   state_e              r_state;
   logic [NUM_CH-1:0]   r_mask;
   logic [CNT_W-1:0]    r_gap;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_gap_cnt;
   logic [CNT_W-1:0]    r_scans_done;
   logic [CH_W-1:0]     r_ptr;
   logic [CH_W-1:0]     r_trig_ch;
   logic                r_trig;
   logic                r_first;
   logic                r_last;
   logic                r_done;
   logic                r_mask_err;

   logic                w_found;
   logic                w_is_last;
   logic [CH_W-1:0]     w_idx;
   logic [CNT_W-1:0]    w_scans_next;

   xsm_ch_priority_find #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_find (
      .i_mask   (r_mask),
      .i_ptr    (r_ptr),
      .o_found  (w_found),
      .o_index  (w_idx),
      .o_is_last(w_is_last)
   );

   assign w_scans_next = r_scans_done + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_mask       <= '0;
         r_gap        <= '0;
         r_count      <= '0;
         r_gap_cnt    <= '0;
         r_scans_done <= '0;
         r_ptr        <= '0;
         r_trig_ch    <= '0;
         r_trig       <= 1'b0;
         r_first      <= 1'b0;
         r_last       <= 1'b0;
         r_done       <= 1'b0;
         r_mask_err   <= 1'b0;
      end else begin
         r_trig     <= 1'b0;
         r_first    <= 1'b0;
         r_last     <= 1'b0;
         r_done     <= 1'b0;
         r_mask_err <= 1'b0;
         // Abort outranks everything, including a coincident start.
         if (i_abort) begin
            r_state <= IDLE;
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_start) begin
                     if (|i_ch_mask) begin
                        r_mask       <= i_ch_mask;
                        r_gap        <= i_gap_cycles;
                        r_count      <= i_scan_count;
                        r_scans_done <= '0;
                        r_ptr        <= '0;
                        r_state      <= SCAN;
                     end else begin
                        r_mask_err <= 1'b1;
                     end
                  end
               end
               SCAN: begin
                  if (i_ds_ready && w_found) begin
                     r_trig    <= 1'b1;
                     r_trig_ch <= w_idx;
                     r_first   <= (r_ptr == '0);
                     r_last    <= w_is_last;
                     if (w_is_last) begin
                        r_scans_done <= w_scans_next;
                        r_ptr        <= '0;
                        if ((r_count != '0) && (w_scans_next == r_count)) begin
                           r_state <= DONE;
                        end else if (r_gap != '0) begin
                           r_gap_cnt <= r_gap;
                           r_state   <= GAP;
                        end
                     end else begin
                        r_ptr <= w_idx + CH_W'(1);
                     end
                  end
               end
               GAP: begin
                  if (r_gap_cnt == CNT_W'(1)) r_state <= SCAN;
                  else r_gap_cnt <= r_gap_cnt - CNT_W'(1);
               end
               DONE: begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_trig_out      = r_trig;
   assign o_trig_ch       = r_trig_ch;
   assign o_first_in_scan = r_first;
   assign o_last_in_scan  = r_last;
   assign o_busy          = (r_state != IDLE);
   assign o_done          = r_done;
   assign o_scans_done    = r_scans_done;
   assign o_mask_err      = r_mask_err;
endmodule

// File: tb/tb_xsm_capture_sequencer.sv
// tb/tb_xsm_capture_sequencer.sv - scoreboard bench for xsm_capture_sequencer
module tb_xsm_capture_sequencer;
   localparam int NUM_CH = 12;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic              i_abort = 1'b0;
   logic [NUM_CH-1:0] i_ch_mask = '0;
   logic [CNT_W-1:0]  i_gap_cycles = '0;
   logic [CNT_W-1:0]  i_scan_count = '0;
   logic              i_ds_ready = 1'b0;
   logic              o_trig_out;
   logic [3:0]        o_trig_ch;
   logic              o_first_in_scan;
   logic              o_last_in_scan;
   logic              o_busy;
   logic              o_done;
   logic [CNT_W-1:0]  o_scans_done;
   logic              o_mask_err;

   xsm_capture_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_start        (i_start),
      .i_abort        (i_abort),
      .i_ch_mask      (i_ch_mask),
      .i_gap_cycles   (i_gap_cycles),
      .i_scan_count   (i_scan_count),
      .i_ds_ready     (i_ds_ready),
      .o_trig_out     (o_trig_out),
      .o_trig_ch      (o_trig_ch),
      .o_first_in_scan(o_first_in_scan),
      .o_last_in_scan (o_last_in_scan),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_scans_done   (o_scans_done),
      .o_mask_err     (o_mask_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int ch;
      bit first;
      bit last;
      int sd;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   done_cnt = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Expected trigger list from the channel list: one entry per enabled channel per scan,
   // consecutive within a scan, gap idle cycles between scans, done one cycle after the last.
   task automatic model_run(input logic [NUM_CH-1:0] mask, input int gap, input int count,
                            input int t0, input bit timed, input int n_scans,
                            input int stall_ch, input int stall_len);
      int   chans[$];
      int   c;
      exp_t e;
      for (int i = 0; i < NUM_CH; i++) if (mask[i]) chans.push_back(i);
      c = t0 + 2;
      for (int s = 1; s <= n_scans; s++) begin
         foreach (chans[j]) begin
            e.ch    = chans[j];
            e.first = (j == 0);
            e.last  = (j == chans.size() - 1);
            e.sd    = e.last ? s : s - 1;
            e.cyc   = timed ? c : -1;
            exp_q.push_back(e);
            c++;
            if (chans[j] == stall_ch) c += stall_len;
         end
         if (count != 0 && s == count) done_q.push_back(timed ? c : -1);
         c += gap;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   d;
      if (rst_n) begin
         if (o_trig_out) begin
            if (exp_q.size() == 0) begin
               check("unexpected_trig", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("trig_ch", o_trig_ch, e.ch);
               check("first_in_scan", o_first_in_scan, e.first);
               check("last_in_scan", o_last_in_scan, e.last);
               check("scans_done_at_trig", o_scans_done, e.sd);
               if (e.cyc >= 0) check("trig_cycle", cyc, e.cyc);
            end
         end
         if (o_done) begin
            done_cnt++;
            check("done_busy_low", o_busy, 0);
            if (done_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               d = done_q.pop_front();
               if (d >= 0) check("done_cycle", cyc, d);
            end
         end
      end
   end

   task automatic start_run(input logic [NUM_CH-1:0] mask, input int gap, input int count,
                            input bit with_abort, output int t0);
      @(negedge clk);
      i_ch_mask    = mask;
      i_gap_cycles = CNT_W'(gap);
      i_scan_count = CNT_W'(count);
      i_start      = 1'b1;
      i_abort      = with_abort;
      t0           = cyc;
   endtask

   // Scrambles configuration while idle-or-busy to show the latched values govern the run.
   task automatic idle_cfg();
      i_start      = 1'b0;
      i_abort      = 1'b0;
      i_ch_mask    = NUM_CH'($urandom);
      i_gap_cycles = CNT_W'($urandom);
      i_scan_count = CNT_W'($urandom);
   endtask

   task automatic wait_done(input string name, input int budget, input bit rand_ready,
                            input int stall_lo, input int stall_hi);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
         idle_cfg();
         if (rand_ready) i_ds_ready = ($urandom_range(0, 3) != 0);
         else i_ds_ready = !(cyc >= stall_lo && cyc <= stall_hi);
         if (o_busy && $urandom_range(0, 7) == 0) i_start = 1'b1;
      end
      check({name, "_completed"}, (n < budget), 1);
      @(negedge clk);
      idle_cfg();
      i_ds_ready = 1'b1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_trig"}, o_trig_out, 0);
      check({name, "_ch"}, o_trig_ch, 0);
      check({name, "_first"}, o_first_in_scan, 0);
      check({name, "_last"}, o_last_in_scan, 0);
      check({name, "_busy"}, o_busy, 0);
      check({name, "_done"}, o_done, 0);
      check({name, "_sd"}, o_scans_done, 0);
      check({name, "_merr"}, o_mask_err, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int                t;
      logic [NUM_CH-1:0] m;
      int                g;
      int                k;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      i_ds_ready = 1'b1;

      // Four consecutive channels, single scan.
      start_run(12'h00F, 0, 1, 0, t);
      model_run(12'h00F, 0, 1, t, 1, 1, -1, 0);
      wait_done("r037", 60, 0, -1, -2);
      check("r037_scans_done", o_scans_done, 1);
      check("r037_drained", exp_q.size(), 0);

      // Two sparse channels, gap of three, two scans.
      start_run(12'h801, 3, 2, 0, t);
      model_run(12'h801, 3, 2, t, 1, 2, -1, 0);
      wait_done("r038", 60, 0, -1, -2);
      check("r038_scans_done", o_scans_done, 2);
      check("r038_drained", exp_q.size(), 0);

      // Downstream stall after channel 4 for five cycles.
      start_run(12'hFFF, 0, 1, 0, t);
      model_run(12'hFFF, 0, 1, t, 1, 1, 4, 5);
      wait_done("r039", 80, 0, t + 6, t + 10);
      check("r039_drained", exp_q.size(), 0);

      // Empty mask rejected; abort wins over start.
      start_run(12'h000, 0, 1, 0, t);
      @(negedge clk);
      idle_cfg();
      check("r040_mask_err_pulse", o_mask_err, 1);
      check("r040_busy_low", o_busy, 0);
      @(negedge clk);
      check("r040_mask_err_single", o_mask_err, 0);
      start_run(12'h000, 0, 1, 1, t);
      @(negedge clk);
      idle_cfg();
      check("r040_abort_no_err", o_mask_err, 0);
      start_run(12'h00F, 0, 1, 1, t);
      @(negedge clk);
      idle_cfg();
      check("r040_abort_no_busy", o_busy, 0);
      @(negedge clk);
      check("r040_abort_still_idle", o_busy, 0);

      // Continuous single channel, abort after the third trigger.
      start_run(12'h001, 0, 0, 0, t);
      model_run(12'h001, 0, 0, t, 1, 3, -1, 0);
      @(negedge clk);
      idle_cfg();
      repeat (3) @(negedge clk);
      i_abort = 1'b1;
      @(negedge clk);
      i_abort = 1'b0;
      check("r041_trig_dropped", o_trig_out, 0);
      check("r041_busy_low", o_busy, 0);
      check("r041_scans_held", o_scans_done, 3);
      repeat (3) @(negedge clk);
      check("r041_still_quiet", o_trig_out, 0);
      check("r041_drained", exp_q.size(), 0);
      check("r041_no_done", done_q.size(), 0);

      // Reset in the middle of a gap, then a clean rerun.
      start_run(12'h801, 10, 3, 0, t);
      model_run(12'h801, 10, 3, t, 1, 1, -1, 0);
      @(negedge clk);
      idle_cfg();
      repeat (6) @(negedge clk);
      check("r042_in_gap_busy", o_busy, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("r042_async");
      check("r042_drained", exp_q.size(), 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_run(12'h00F, 0, 1, 0, t);
      model_run(12'h00F, 0, 1, t, 1, 1, -1, 0);
      wait_done("r042_rerun", 60, 0, -1, -2);
      check("r042_rerun_scans", o_scans_done, 1);

      // Randomized runs with random backpressure.
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 2) == 0) m = NUM_CH'(1) << $urandom_range(0, NUM_CH - 1);
         else m = NUM_CH'($urandom);
         if (m == '0) m = 12'h040;
         g = $urandom_range(0, 3);
         k = $urandom_range(1, 3);
         start_run(m, g, k, 0, t);
         model_run(m, g, k, t, 0, k, -1, 0);
         wait_done("rand_run", 2000, 1, -1, -2);
         check("rand_scans_done", o_scans_done, k);
         check("rand_drained", exp_q.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
